// File: rtl/uart_loader_if.sv
// Byte stream in from the UART receiver and instruction-memory write port out.
// The loader is the master: it consumes rx bytes and drives the memory write.
interface uart_loader_if #(
   parameter int ADDR_W = 12
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: parses A5/len/data/csum frames into instruction-memory writes
// and holds the CPU in reset until a frame loads with a matching checksum.
module uart_loader #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 500000
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_loader_if.master bus,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          load_done,
   output logic          err
);

   localparam logic [7:0]  SYNC      = 8'hA5;
   localparam int          IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE} state_t;

   state_t            state;
   logic [7:0]        len_lo;
   logic [15:0]       words_left;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_cnt;
   logic [7:0]        csum;
   logic [23:0]       data_buf;
   logic [IDLE_W-1:0] idle_cnt;

   logic [15:0] len_rx;
   logic        len_bad;
   assign len_rx  = {bus.rx_data, len_lo};
   assign len_bad = (len_rx == 16'd0) || ({17'd0, len_rx} > MAX_WORDS);

   // NOTE: every register below is updated with <= so all branches see the
   // pre-edge values; mixing in = here would make results depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_rst_n      <= 1'b1;
         busy           <= 1'b0;
         load_done      <= 1'b0;
         err            <= 1'b0;
         len_lo         <= '0;
         words_left     <= '0;
         word_idx       <= '0;
         byte_cnt       <= '0;
         csum           <= '0;
         data_buf       <= '0;
         idle_cnt       <= '0;
      end else begin
         bus.imem_we <= 1'b0;
         load_done   <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.rx_valid && bus.rx_data == SYNC) begin
                  state     <= LEN0;
                  busy      <= 1'b1;
                  cpu_rst_n <= 1'b0;
                  csum      <= '0;
                  byte_cnt  <= '0;
                  word_idx  <= '0;
                  idle_cnt  <= '0;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               if (bus.rx_valid) begin
                  // An arriving byte always wins over a timeout in the same cycle.
                  idle_cnt <= '0;
                  case (state)
                     LEN0: begin
                        len_lo <= bus.rx_data;
                        state  <= LEN1;
                     end
                     LEN1: begin
                        if (len_bad) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           err   <= 1'b1;
                        end else begin
                           words_left <= len_rx;
                           state      <= DATA;
                        end
                     end
                     DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum + bus.rx_data;
                        if (byte_cnt == 2'd3) begin
                           bus.imem_we    <= 1'b1;
                           bus.imem_addr  <= word_idx;
                           bus.imem_wdata <= {bus.rx_data, data_buf};
                           word_idx       <= word_idx + 1'b1;
                           words_left     <= words_left - 16'd1;
                           if (words_left == 16'd1) state <= CSUM;
                        end else begin
                           // Shift right so byte 0 ends up in the low lane after three bytes.
                           data_buf <= {bus.rx_data, data_buf[23:8]};
                        end
                     end
                     CSUM: begin
                        if (bus.rx_data == csum) begin
                           state     <= DONE;
                           load_done <= 1'b1;
                           cpu_rst_n <= 1'b1;
                           err       <= 1'b0;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           err   <= 1'b1;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised frame bench for uart_loader: a driver pushes expected memory writes and
// load pulses into a scoreboard queue, an independent monitor pops and compares them.
module tb_uart_loader;

   localparam int ADDR_W  = 12;
   localparam int TIMEOUT = 16;
   localparam int MAXN    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_rst_n, busy, load_done, err;

   uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

   uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .load_done (load_done),
      .err       (err)
   );

   always #10 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit                is_done;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      longint            cyc;
   } ev_t;

   ev_t         exp_q[$];
   logic [31:0] words_q[$];
   logic        exp_err = 1'b0;
   logic        exp_cpu = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write or load pulse must match the oldest expected event.
   logic [ADDR_W-1:0] last_addr = '0;
   logic [31:0]       last_data = '0;
   always @(negedge clk) begin : monitor
      ev_t ev;
      if (!rst_n) begin
         last_addr = '0;
         last_data = '0;
      end else begin
         if (bus.imem_we || load_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", {62'd0, bus.imem_we, load_done}, 64'd0);
            end else begin
               ev = exp_q.pop_front();
               if (ev.is_done) begin
                  check("load_done_pulse", {63'd0, load_done}, 64'd1);
                  check("load_done_cycle", cyc, ev.cyc);
               end else begin
                  check("write_we", {63'd0, bus.imem_we}, 64'd1);
                  check("write_addr", 64'(bus.imem_addr), 64'(ev.addr));
                  check("write_data", 64'(bus.imem_wdata), 64'(ev.data));
                  check("write_cycle", cyc, ev.cyc);
               end
            end
         end
         if (bus.imem_we) begin
            last_addr = bus.imem_addr;
            last_data = bus.imem_wdata;
         end else begin
            check("addr_hold", 64'(bus.imem_addr), 64'(last_addr));
            check("wdata_hold", 64'(bus.imem_wdata), 64'(last_data));
         end
      end
   end

   // Driver sits just after a rising edge on entry and exit.
   task automatic send_byte(input logic [7:0] b, input int gap, input int kind,
                            input logic [ADDR_W-1:0] addr, input logic [31:0] data);
      ev_t ev;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      if (kind != 0) begin
         ev.is_done = (kind == 2);
         ev.addr    = addr;
         ev.data    = data;
         ev.cyc     = cyc + 1;
         exp_q.push_back(ev);
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic fill_words(input int n);
      words_q.delete();
      for (int w = 0; w < n; w++) words_q.push_back($urandom);
   endtask

   task automatic check_settled(input string tag);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
      check({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, {63'd0, exp_cpu});
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_missing_events"}, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Reference model: expected events come straight from the frame layout
   // (header of 3 bytes, 4 bytes per word, trailing checksum).
   task automatic run_frame(input string tag, input int n, input int delta, input int stop,
                            input int max_gap, input int long_gap_at);
      logic [7:0]  bytes[$];
      logic [7:0]  sum;
      logic [15:0] n16;
      bit          valid_len;
      int          nsend;
      int          kind;
      int          gap;
      int          idle;
      int          widx;
      logic [7:0]  b;
      logic [7:0]  d8;
      n16 = 16'(n);
      d8  = 8'(delta);
      sum = 8'd0;
      bytes.push_back(8'hA5);
      bytes.push_back(n16[7:0]);
      bytes.push_back(n16[15:8]);
      for (int w = 0; w < n && w < words_q.size(); w++) begin
         for (int k = 0; k < 4; k++) begin
            b = words_q[w][8*k +: 8];
            bytes.push_back(b);
            sum = sum + b;
         end
      end
      bytes.push_back(sum + d8);
      valid_len = (n >= 1) && (n <= MAXN);
      nsend = (stop < 0) ? bytes.size() : stop;

      for (int i = 0; i < nsend; i++) begin
         kind = 0;
         widx = (i - 3) / 4;
         if (valid_len && i >= 3 && i < 3 + 4*n && ((i - 3) % 4) == 3) kind = 1;
         if (valid_len && i == 3 + 4*n && d8 == 8'd0) kind = 2;
         if (i == 0) gap = 0;
         else if (i == long_gap_at) gap = TIMEOUT - 1;
         else gap = int'($urandom_range(0, max_gap));
         send_byte(bytes[i], gap, kind, ADDR_W'(widx), (kind == 1) ? words_q[widx] : 32'd0);
         if (i == 0) begin
            @(negedge clk);
            check({tag, "_busy_after_sync"}, {63'd0, busy}, 64'd1);
            check({tag, "_cpu_held_after_sync"}, {63'd0, cpu_rst_n}, 64'd0);
            @(posedge clk);
            #1;
         end
      end

      if (valid_len && nsend == bytes.size() && d8 == 8'd0) begin
         exp_err = 1'b0;
         exp_cpu = 1'b1;
      end else begin
         if (valid_len && nsend < bytes.size()) begin
            idle = 0;
            while (idle < 4*TIMEOUT) begin
               @(posedge clk);
               idle++;
               @(negedge clk);
               if (!busy) break;
            end
            check({tag, "_timeout_cycles"}, 64'(idle), 64'(TIMEOUT));
            @(posedge clk);
            #1;
         end
         exp_err = 1'b1;
         exp_cpu = 1'b0;
      end
      check_settled(tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      #25;
      check("rst_imem_we", {63'd0, bus.imem_we}, 64'd0);
      check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
      check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
      check("rst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_load_done", {63'd0, load_done}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      words_q.delete();
      words_q.push_back(32'h0000_0013);
      words_q.push_back(32'h0010_0093);
      run_frame("two_word_ok", 2, 0, -1, 2, -1);
      run_frame("bad_csum", 2, 1, -1, 2, -1);

      send_byte(8'h00, 0, 0, '0, '0);
      send_byte(8'hFF, 2, 0, '0, '0);
      fill_words(1);
      run_frame("junk_prefix", 1, 0, -1, 3, -1);

      fill_words(0);
      run_frame("len_zero", 0, 0, 3, 2, -1);
      run_frame("len_too_big", MAXN + 1, 0, 3, 2, -1);

      for (int f = 0; f < 12; f++) begin
         int n;
         int delta;
         n = int'($urandom_range(1, 6));
         fill_words(n);
         words_q[0][7:0] = 8'hA5;
         if ($urandom_range(0, 1) == 1) words_q[n-1][31:24] = 8'hA5;
         delta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
         run_frame("random", n, delta, -1, TIMEOUT - 1, (f == 2) ? 5 : -1);
      end

      fill_words(3);
      run_frame("timeout", 3, 0, 8, 2, -1);
      fill_words(2);
      run_frame("after_timeout", 2, 0, -1, 2, -1);

      // Abandon a frame with reset after three data bytes.
      send_byte(8'hA5, 0, 0, '0, '0);
      send_byte(8'h02, 1, 0, '0, '0);
      send_byte(8'h00, 0, 0, '0, '0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 0, '0, '0);
      rst_n = 1'b0;
      #2;
      check("midrst_imem_we", {63'd0, bus.imem_we}, 64'd0);
      check("midrst_imem_addr", 64'(bus.imem_addr), 64'd0);
      check("midrst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
      check("midrst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_err", {63'd0, err}, 64'd0);
      repeat (2) @(posedge clk);
      #5;
      rst_n = 1'b1;
      exp_err = 1'b0;
      exp_cpu = 1'b1;
      @(posedge clk);
      #1;
      send_byte(8'h11, 0, 0, '0, '0);
      fill_words(1);
      run_frame("after_reset", 1, 0, -1, 2, -1);

      fill_words(MAXN);
      run_frame("max_len", MAXN, 0, -1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 500000, meaning the number of idle clk cycles allowed between bytes inside a frame (10 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1, system clock (50 MHz).
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port rx_valid, input, 1, single-cycle strobe from the UART receiver marking a valid byte.
REQ-006 The block SHALL have port rx_data, input, 8, received byte, valid only while rx_valid=1.
REQ-007 The block SHALL have port imem_we, output, 1, instruction-memory write enable.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W, instruction-memory word address.
REQ-009 The block SHALL have port imem_wdata, output, 32, instruction-memory write data.
REQ-010 The block SHALL have port cpu_rst_n, output, 1, active-low hold for the CPU core.
REQ-011 The block SHALL have port busy, output, 1, frame in progress.
REQ-012 The block SHALL have port load_done, output, 1, one-cycle pulse on successful load.
REQ-013 The block SHALL have port err, output, 1, sticky load-failure flag.

Function
REQ-014 Frame format SHALL be: sync 0xA5, LEN_L, LEN_H (16-bit word count N, little-endian), 4*N data bytes (little-endian per word), CSUM.
REQ-015 CSUM SHALL equal the 8-bit modulo-256 sum of the 4*N data bytes only, excluding sync and length.
REQ-016 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, CSUM, DONE.
REQ-017 IDLE: rx_valid with rx_data=0xA5 -> LEN0; any other byte SHALL be ignored.
REQ-018 LEN0: a byte -> LEN1, latched as LEN[7:0].
REQ-019 LEN1: a byte is latched as LEN[15:8], and the FSM SHALL then branch on N.
REQ-020 LEN1 branch: N=0 or N>2^ADDR_W SHALL raise an error; otherwise -> DATA.
REQ-021 DATA: each byte SHALL be placed in lane byte_cnt[1:0], with byte 0 in [7:0], and added to the running checksum.
REQ-022 DATA: on the 4th byte of a word, imem_we SHALL be 1 for exactly one cycle on the next clk, with imem_wdata={b3,b2,b1,b0}.
REQ-023 DATA write address: imem_addr SHALL be the word index, starting at 0 and incrementing after each write.
REQ-024 DATA: after word N is written the FSM -> CSUM.
REQ-025 CSUM: a byte equal to the running checksum -> DONE; a mismatch SHALL raise an error.
REQ-026 DONE SHALL last one cycle, pulse load_done=1, set cpu_rst_n=1, clear err, then -> IDLE.
REQ-027 On accepting the sync byte: cpu_rst_n SHALL go 0 and busy SHALL go 1 on the next clk.
REQ-028 On accepting the sync byte: the checksum, byte counter and word counter SHALL clear.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Error action: err SHALL become 1 and the FSM -> IDLE.
REQ-031 After an error, cpu_rst_n SHALL stay 0 and err SHALL stay 1 until a later successful DONE.
REQ-032 Timeout: in LEN0, LEN1, DATA and CSUM, an idle counter SHALL clear on each rx_valid and increment otherwise.
REQ-033 Timeout: when the idle counter reaches TIMEOUT, an error SHALL be raised.
REQ-034 If rx_valid coincides with the timeout cycle, the byte SHALL take priority and no error SHALL be raised.
REQ-035 A sync byte received mid-frame SHALL be treated as ordinary data; there SHALL be no resynchronisation.
REQ-036 Latency: imem_we SHALL assert 1 cycle after the rx_valid of each 4th byte.
REQ-037 Latency: load_done SHALL assert 1 cycle after the rx_valid of a correct CSUM.
REQ-038 imem_addr and imem_wdata SHALL hold their values while imem_we=0.
REQ-039 The block SHALL be able to accept rx_valid on consecutive cycles.

Reset
REQ-040 On rst_n=0, asynchronously: FSM=IDLE, imem_we=0, imem_addr=0, imem_wdata=0.
REQ-041 On rst_n=0, asynchronously: cpu_rst_n=1, busy=0, load_done=0, err=0, and all counters and the checksum = 0.
REQ-042 Reset asserted mid-frame SHALL abandon the frame; no further imem_we SHALL occur.

Verification
REQ-043 Bytes A5 02 00 13 00 00 00 93 00 10 00 CS=B6 -> writes [0]=00000013 and [1]=00100093, then load_done pulse, cpu_rst_n=1, err=0.
REQ-044 Same frame with CS=B7 -> both writes occur, no load_done, err=1, cpu_rst_n=0, FSM=IDLE.
REQ-045 Bytes 00 FF then A5 01 00 ... -> the first two bytes are ignored and the load completes normally.
REQ-046 LEN=0x0000, or LEN=0x1001 with ADDR_W=12 -> err=1, no imem_we.
REQ-047 With TIMEOUT=16, stop after 5 data bytes -> err=1 at 16 idle cycles, one write occurred; a following valid frame clears err.
REQ-048 Assert rst_n=0 after 3 data bytes, release, then send a fresh one-word frame -> exactly one write to address 0, load_done=1.
